mjpg_stream_packer: RTL and testbench
=====================================

Name: mjpg_stream_packer

Overview:
- Takes the encoder's unthrottled JPEG byte stream (valid + 8-bit data) and packs it into BYTES_PER_WORD-wide words with selectable byte order.
- Detects SOI/EOI markers to frame the stream. Buffers words in a FIFO with a ready/valid output toward the capture sink (DMA/Ethernet).
- Successor to fixed 32-bit host-side packing: generalised width, endianness, frame tagging, backpressure and overflow reporting.

Parameters:
- BYTES_PER_WORD, 4, output word width in bytes (>=1).
- BIG_ENDIAN, 1, 1: first byte in MSB lane; 0: first byte in LSB lane.
- FIFO_DEPTH, 16, word FIFO entries (power of 2, >=2).
- PAD_BYTE, 8'h00, filler for unused lanes of a short word.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  byte strobe from encoder; no backpressure
- in_data  in  8  JPEG byte
- flush  in  1  emit pending partial word
- clear_overflow  in  1  clears overflow flag
- out_valid  out  1  FIFO head valid
- out_ready  in  1  sink accepts
- out_data  out  8*BYTES_PER_WORD  packed word
- out_keep  out  BYTES_PER_WORD  per-lane byte valid, same lane mapping as data
- out_last  out  1  word contains EOI's D9 byte
- frame_done  out  1  one-cycle pulse when an EOI word is pushed
- frame_bytes  out  32  bytes from SOI FF through EOI D9 inclusive
- overflow  out  1  sticky: a word was dropped

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, lane index 0, prev_ff 0, partial word discarded.
- Assembly: each in_valid byte goes to lane k, then k increments. Byte 0 goes to lane 0 = MSB byte if BIG_ENDIAN, else LSB byte.
- Word completes when k reaches BYTES_PER_WORD-1 with in_valid. The completed word is pushed to the FIFO on the following edge.
- Marker detection: prev_ff is set on an 0xFF byte and cleared on any other byte.
  - 0xD8 with prev_ff = SOI: frame_bytes loads 2 (counts the FF too).
  - 0xD9 with prev_ff = EOI: the current word is closed immediately, even if partial.
  - FF FF D9 is still EOI. FF 00 D9 is not.
  - Markers split across words are detected normally.
- Outside SOI..EOI, frame_bytes holds its value. Inside, it increments per byte and includes the D9.
- Short word, from EOI or flush: unused lanes = PAD_BYTE with keep=0. out_last=1 only for EOI.
- flush: one-cycle request.
  - If k>0 it closes the partial word with last=0.
  - If an in_valid byte arrives in the same cycle, that byte is included first.
  - If the word is full or k==0 after that byte, flush is a no-op.
- Push timing: byte captured at edge E; word written to FIFO at edge E+1. out_valid is high in the cycle after E+1 if the FIFO was empty (first-word-fall-through).
- frame_done pulses in the same cycle as the EOI word push. frame_bytes is final at that point.
- FIFO:
  - out_valid = not empty. Transfer when out_valid && out_ready. out_data/keep/last are stable while out_valid && !out_ready.
  - A push when full is accepted only if a pop occurs in the same cycle. Otherwise the word is dropped and overflow=1.
  - Assembly continues after a drop. A dropped EOI word still pulses frame_done.
- clear_overflow clears overflow next edge. If clear and a new drop coincide, overflow stays 1.
- Back-to-back words at BYTES_PER_WORD=1: one push per cycle, sustained without loss while out_ready=1.

Test Plan:
- BYTES_PER_WORD=4, BIG_ENDIAN=1, out_ready=1, bytes 01..08 -> words 0x01020304 then 0x05060708, keep 4'b1111, last 0.
- BIG_ENDIAN=0, same stimulus -> 0x04030201, 0x08070605.
- Bytes FF D8 AA FF D9 -> words 0xFFD8AAFF (keep 1111) and 0xD9000000 (keep 1000, last 1). frame_done pulses once; frame_bytes=5.
- FF 00 D9 AB -> no EOI, single full word 0xFF00D9AB, last 0. FF FF D9 -> EOI, last 1.
- out_ready=0, 17 words input, depth 16 -> overflow=1, out_data frozen. Then out_ready=1 drains exactly 16 words in order; clear_overflow -> overflow 0.
- Two bytes, then rst pulsed low -> out_valid 0, no word emitted. Next 4 bytes 11 22 33 44 -> 0x11223344. Also 3 bytes + flush -> 0xAABBCC00, keep 1110, last 0.

Source files
------------

// File: rtl/mjpg_stream_packer.sv
// Packs the encoder's JPEG byte stream into BYTES_PER_WORD-wide words and frames
// them by SOI/EOI markers, buffering the words in a FWFT FIFO toward the capture sink.
module mjpg_stream_packer #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter bit          BIG_ENDIAN     = 1'b1,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          flush,
  input  logic                          clear_overflow,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [8*BYTES_PER_WORD-1:0]   out_data,
  output logic [BYTES_PER_WORD-1:0]     out_keep,
  output logic                          out_last,
  output logic                          frame_done,
  output logic [31:0]                   frame_bytes,
  output logic                          overflow
);

  localparam int unsigned W  = 8 * BYTES_PER_WORD;
  localparam int unsigned KW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [KW-1:0] K_LAST   = KW'(BYTES_PER_WORD - 1);
  localparam logic [W-1:0]  PAD_WORD = {BYTES_PER_WORD{PAD_BYTE}};

  typedef enum logic {OUTSIDE, INSIDE} frame_t;

  frame_t                    frame_state, frame_next;
  logic [31:0]               frame_bytes_nxt;
  logic [KW-1:0]             lane;
  logic [W-1:0]              word_buf, word_nxt;
  logic [BYTES_PER_WORD-1:0] keep_buf, keep_nxt;
  logic                      prev_ff;
  logic                      is_soi, is_eoi, close_full, close_flush, close_word;

  logic                      pend_valid, pend_last;
  logic [W-1:0]              pend_data;
  logic [BYTES_PER_WORD-1:0] pend_keep;

  logic [W-1:0]              mem_data [FIFO_DEPTH];
  logic [BYTES_PER_WORD-1:0] mem_keep [FIFO_DEPTH];
  logic                      mem_last [FIFO_DEPTH];
  logic [PW:0]               wr_ptr, rd_ptr;
  logic                      empty, full, pop, push_ok, drop;

  assign is_soi      = in_valid && prev_ff && (in_data == 8'hD8);
  assign is_eoi      = in_valid && prev_ff && (in_data == 8'hD9);
  assign close_full  = in_valid && (lane == K_LAST);
  // A flush coinciding with a byte closes the word only if that byte left it partial.
  assign close_flush = flush && !is_eoi && !close_full && (in_valid || (lane != '0));
  assign close_word  = is_eoi || close_full || close_flush;

  always_comb begin
    word_nxt = word_buf;
    keep_nxt = keep_buf;
    if (in_valid) begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (KW'(i) == lane) begin
          if (BIG_ENDIAN) begin
            word_nxt[8*(BYTES_PER_WORD-1-i) +: 8] = in_data;
            keep_nxt[BYTES_PER_WORD-1-i]          = 1'b1;
          end else begin
            word_nxt[8*i +: 8] = in_data;
            keep_nxt[i]        = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    frame_next      = frame_state;
    frame_bytes_nxt = frame_bytes;
    if (is_soi) begin
      frame_next      = INSIDE;
      frame_bytes_nxt = 32'd2;
    end else if (in_valid && (frame_state == INSIDE)) begin
      frame_bytes_nxt = frame_bytes + 32'd1;
      if (is_eoi) frame_next = OUTSIDE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_state <= OUTSIDE;
      frame_bytes <= '0;
      lane        <= '0;
      word_buf    <= PAD_WORD;
      keep_buf    <= '0;
      prev_ff     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      pend_keep   <= '0;
      pend_last   <= 1'b0;
    end else begin
      frame_state <= frame_next;
      frame_bytes <= frame_bytes_nxt;
      if (in_valid) prev_ff <= (in_data == 8'hFF);
      pend_valid <= close_word;
      if (close_word) begin
        pend_data <= word_nxt;
        pend_keep <= keep_nxt;
        pend_last <= is_eoi;
        lane      <= '0;
        word_buf  <= PAD_WORD;
        keep_buf  <= '0;
      end else begin
        word_buf <= word_nxt;
        keep_buf <= keep_nxt;
        if (in_valid) lane <= lane + KW'(1);
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign pop     = !empty && out_ready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok = pend_valid && (!full || pop);
  assign drop    = pend_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr[PW-1:0]] <= pend_data;
      mem_keep[wr_ptr[PW-1:0]] <= pend_keep;
      mem_last[wr_ptr[PW-1:0]] <= pend_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
      overflow <= drop || (overflow && !clear_overflow);
    end
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_data[rd_ptr[PW-1:0]];
  assign out_keep   = empty ? '0 : mem_keep[rd_ptr[PW-1:0]];
  assign out_last   = !empty && mem_last[rd_ptr[PW-1:0]];
  assign frame_done = pend_valid && pend_last;

endmodule

// File: tb/tb_mjpg_stream_packer.sv
// Directed bench for mjpg_stream_packer: expected words are queued as bytes are
// driven and compared as the sink accepts them; a second instance covers little-endian.
module tb_mjpg_stream_packer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, clear_overflow, out_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_last, frame_done, overflow;
  logic [31:0] out_data, frame_bytes;
  logic [3:0]  out_keep;

  logic        le_in_valid, le_flush, le_clear, le_out_ready;
  logic [7:0]  le_in_data;
  logic        le_out_valid, le_out_last, le_frame_done, le_overflow;
  logic [31:0] le_out_data, le_frame_bytes;
  logic [3:0]  le_out_keep;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [31:0] fb_at_done = '0;
  exp_t        exp_q[$];
  exp_t        le_q[$];

  always #5 clk = ~clk;

  mjpg_stream_packer #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b1), .FIFO_DEPTH(16), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .clear_overflow(clear_overflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .frame_done(frame_done), .frame_bytes(frame_bytes), .overflow(overflow)
  );

  mjpg_stream_packer #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b0), .FIFO_DEPTH(16), .PAD_BYTE(8'h00)) dut_le (
    .clk(clk), .rst(rst), .in_valid(le_in_valid), .in_data(le_in_data), .flush(le_flush),
    .clear_overflow(le_clear), .out_valid(le_out_valid), .out_ready(le_out_ready),
    .out_data(le_out_data), .out_keep(le_out_keep), .out_last(le_out_last),
    .frame_done(le_frame_done), .frame_bytes(le_frame_bytes), .overflow(le_overflow)
  );

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_word observed=%h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        assert ({out_data, out_keep, out_last} === {e.data, e.keep, e.last}) else begin
          bad++;
          $error("FAIL be_word observed=%h/%b/%b expected=%h/%b/%b",
                 out_data, out_keep, out_last, e.data, e.keep, e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && le_out_valid && le_out_ready) begin
      total++;
      assert (le_q.size() != 0) else begin
        bad++;
        $error("FAIL le_unexpected_word observed=%h expected=none", le_out_data);
      end
      if (le_q.size() != 0) begin
        exp_t e;
        e = le_q.pop_front();
        total++;
        assert ({le_out_data, le_out_keep, le_out_last} === {e.data, e.keep, e.last}) else begin
          bad++;
          $error("FAIL le_word observed=%h/%b/%b expected=%h/%b/%b",
                 le_out_data, le_out_keep, le_out_last, e.data, e.keep, e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && frame_done) begin
      done_cnt++;
      fb_at_done = frame_bytes;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_le(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.keep = 4'hF;
    e.last = 1'b0;
    le_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_with_flush(input logic [7:0] b);
    flush = 1'b1;
    send(b);
    flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    int d0;
    logic [31:0] w;
    logic [7:0]  b;

    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; flush = 1'b0; clear_overflow = 1'b0; out_ready = 1'b1;
    le_in_valid = 1'b0; le_in_data = '0; le_flush = 1'b0; le_clear = 1'b0; le_out_ready = 1'b1;
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_keep", out_keep, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_bytes", frame_bytes, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    idle(1);

    // plain packing, both byte orders
    push_exp(32'h01020304, 4'hF, 1'b0);
    push_exp(32'h05060708, 4'hF, 1'b0);
    push_le(32'h04030201);
    push_le(32'h08070605);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      le_in_valid = 1'b1; le_in_data = 8'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; le_in_valid = 1'b0;
    idle(4);

    // framed stream with EOI closing a partial word
    d0 = done_cnt;
    push_exp(32'hFFD8AAFF, 4'hF, 1'b0);
    push_exp(32'hD9000000, 4'h8, 1'b1);
    send(8'hFF); send(8'hD8); send(8'hAA); send(8'hFF); send(8'hD9);
    idle(4);
    check("frame_done_count", done_cnt - d0, 1);
    check("frame_bytes_at_done", fb_at_done, 5);
    check("frame_bytes_live", frame_bytes, 5);

    // FF 00 D9 is not EOI
    push_exp(32'hFF00D9AB, 4'hF, 1'b0);
    send(8'hFF); send(8'h00); send(8'hD9); send(8'hAB);
    idle(3);
    check("stuffed_no_eoi", done_cnt - d0, 1);

    // FF FF D9 is EOI; frame_bytes holds outside a frame
    push_exp(32'hFFFFD900, 4'hE, 1'b1);
    send(8'hFF); send(8'hFF); send(8'hD9);
    idle(4);
    check("ff_ff_d9_eoi", done_cnt - d0, 2);
    check("frame_bytes_hold", frame_bytes, 5);

    // fill the FIFO with the sink stalled, then one word too many
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        b = 8'(4 * i + j + 1);
        w = {w[23:0], b};
        send(b);
      end
      if (i < 16) push_exp(w, 4'hF, 1'b0);
      if (i == 15) begin
        idle(3);
        check("full_no_overflow", overflow, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_head", out_data, 32'h01020304);
      end
    end
    idle(3);
    check("overflow_set", overflow, 1);
    check("stall_head_frozen", out_data, 32'h01020304);
    out_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    idle(3);
    check("drain_all", exp_q.size(), 0);
    check("drained_empty", out_valid, 0);
    check("overflow_sticky", overflow, 1);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    check("overflow_cleared", overflow, 0);

    // reset discards a partial word
    send(8'h55); send(8'h66);
    rst = 1'b0;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_frame_bytes", frame_bytes, 0);
    check("midrst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    push_exp(32'h11223344, 4'hF, 1'b0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(3);

    // flush after a partial word, flush with nothing pending, flush with a byte
    push_exp(32'hAABBCC00, 4'hE, 1'b0);
    send(8'hAA); send(8'hBB); send(8'hCC);
    pulse_flush();
    idle(3);
    pulse_flush();
    idle(3);
    push_exp(32'h01020300, 4'hE, 1'b0);
    send(8'h01); send(8'h02);
    send_with_flush(8'h03);
    idle(3);
    push_exp(32'h05060708, 4'hF, 1'b0);
    send(8'h05); send(8'h06); send(8'h07);
    send_with_flush(8'h08);
    idle(6);

    check("be_queue_empty", exp_q.size(), 0);
    check("le_queue_empty", le_q.size(), 0);
    check("frame_done_total", done_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
